// File: rtl/delay_scheduler.sv
// Shared delay counter: grants one requester at a time in round-robin order,
// counts its delay down and pulses done_pulse to the owner when it expires.
module delay_scheduler #(
  parameter  int unsigned NUM_REQ  = 4,
  parameter  int unsigned BW_DELAY = 32,
  localparam int unsigned BW_ID    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rstnn,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*BW_DELAY-1:0] req_delay,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        abort,
  output logic [NUM_REQ-1:0]          done_pulse,
  output logic                        busy,
  output logic [BW_ID-1:0]            active_id,
  output logic [BW_DELAY-1:0]         remaining
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_t;

  state_t               r_state;
  logic [BW_ID-1:0]     r_rr_ptr;
  logic [BW_ID-1:0]     r_active_id;
  logic [BW_DELAY-1:0]  r_remaining;
  logic [NUM_REQ-1:0]   r_done;
  logic                 r_busy;

  logic                 w_found;
  logic [BW_ID-1:0]     w_gid;
  logic [BW_ID-1:0]     w_idx;
  logic [BW_ID-1:0]     w_next_ptr;
  logic [BW_DELAY-1:0]  w_gdelay;

  // First valid requester at or after the round-robin pointer, with wrap.
  always_comb begin
    w_found = 1'b0;
    w_gid   = '0;
    w_idx   = r_rr_ptr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gid   = w_idx;
      end
      w_idx = (w_idx == BW_ID'(NUM_REQ - 1)) ? '0 : w_idx + BW_ID'(1);
    end
  end

  always_comb begin
    w_gdelay = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gid == BW_ID'(i)) w_gdelay = req_delay[i*BW_DELAY +: BW_DELAY];
    end
  end

  assign w_next_ptr = (w_gid == BW_ID'(NUM_REQ - 1)) ? '0 : w_gid + BW_ID'(1);

  // Grant is offered only while idle and out of reset.
  assign req_ready = (rstnn && (r_state == S_IDLE) && w_found) ?
                     (NUM_REQ'(1) << w_gid) : '0;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_active_id <= '0;
      r_remaining <= '0;
      r_done      <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_remaining <= w_gdelay;
            r_active_id <= w_gid;
            r_rr_ptr    <= w_next_ptr;
            r_state     <= S_COUNT;
            r_busy      <= 1'b1;
          end
        end
        S_COUNT: begin
          // Abort takes priority over a completion on the same edge.
          if (abort) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_active_id <= '0;
            r_busy      <= 1'b0;
          end else if (r_remaining == '0) begin
            r_done      <= NUM_REQ'(1) << r_active_id;
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_active_id <= '0;
            r_busy      <= 1'b0;
          end else begin
            r_remaining <= r_remaining - BW_DELAY'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign done_pulse = r_done;
  assign busy       = r_busy;
  assign active_id  = r_active_id;
  assign remaining  = r_remaining;

  // A waiting requester must keep its request up until it is granted.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_hold_chk
    a_hold_valid: assert property (@(posedge clk) disable iff (!rstnn)
      (req_valid[gi] && !req_ready[gi]) |=> req_valid[gi]);
  end

endmodule
